imc_operand_packer: RTL and testbench
=====================================

# imc_operand_packer

- Parametrised operand collector for the IMC datapath.
- Accepts operands one word at a time from a valid/accept producer and packs `NUM_OPERANDS` of them into a flat parallel bus.
- Launches the packed frame to the IMC core with a single-cycle `start` once the core reports `imc_ready`.
- Successor to the fixed 4×16-bit input stage: configurable width and operand count, back-pressure on the producer, frame-size reporting, and an optional partial-frame flush.

## Interface
- `DATA_WIDTH`, 16, width of one operand word.
- `NUM_OPERANDS`, 4, words per frame; legal range 2..16.
- `CNT_W`, derived localparam `$clog2(NUM_OPERANDS+1)`, width of counters.

- `clk` input 1: single clock; all state updates on its rising edge.
- `rst_n` input 1: synchronous, active-high reset. Despite the `_n` suffix, a high level resets.
- `data_in` input DATA_WIDTH: operand word from the producer.
- `data_valid` input 1: producer offers `data_in` this cycle.
- `data_accept` output 1: block can take a word this cycle. A transfer occurs on any edge where `data_valid` and `data_accept` are both high.
- `imc_ready` input 1: IMC core can take a frame.
- `start` output 1: one-cycle pulse; frame is handed to the IMC on this cycle.
- `operands` output NUM_OPERANDS*DATA_WIDTH: packed frame. Slot 0 is in the LSBs, slot i is at `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `valid_count` output CNT_W: number of meaningful slots in the frame. Valid while `start` is high.
- `busy` output 1: high while a frame waits for launch.
- `flush` input 1: request launch of a partial frame. Only effective with `IMC_PACKER_FLUSH_EN`.

## Operation
- FSM has two states.
  - COLLECT: reset state.
  - LAUNCH.
- COLLECT:
  - `data_accept` = 1 and `busy` = 0.
  - On each transfer, `data_in` is written to slot[`count`] and `count` increments.
  - The transfer that makes `count` = NUM_OPERANDS moves the FSM to LAUNCH.
- LAUNCH:
  - `data_accept` = 0 and `busy` = 1.
  - `operands` and `valid_count` are held stable.
  - `start` = `imc_ready` (combinational, gated by state).
  - On an edge with `imc_ready` high: return to COLLECT and clear `count` to 0.
  - Otherwise remain in LAUNCH indefinitely. The producer is stalled with no word loss.
- `valid_count` is registered.
  - Loaded with the frame size on entry to LAUNCH: NUM_OPERANDS, or the partial count on a flush.
  - Holds its value in COLLECT.
- `operands` is driven directly from the slot registers.
  - In COLLECT, slots update as words arrive; consumers sample only when `start` is high.
  - Slots keep their values after launch until overwritten.
- Counter arithmetic is CNT_W-bit unsigned. `count` never exceeds NUM_OPERANDS and never wraps.
- Reset (any state, any cycle), effective at the next edge:
  - state = COLLECT, `count` = 0, `valid_count` = 0, all slots = 0.
  - A partial or pending frame is discarded; no `start` is emitted.
- Output values while `rst_n` is high: `data_accept` = 0, `start` = 0, `busy` = 0, `operands` = 0, `valid_count` = 0.

## Timing
- Word k is captured at the edge where the transfer is seen. It appears on `operands` in the following cycle.
- The Nth transfer at edge t puts the FSM in LAUNCH in cycle t+1.
  - If `imc_ready` is already high, `start` is high in cycle t+1.
  - `data_accept` returns high in cycle t+2.
- Minimum frame period with continuous `data_valid` and `imc_ready`: NUM_OPERANDS+1 cycles.
- `start` is never high for two consecutive cycles.
- `imc_ready` falling while in LAUNCH: no `start`; the FSM keeps waiting.

## Configuration
- Macro: `IMC_PACKER_FLUSH_EN`.
- Defined:
  - A `flush` high in COLLECT moves the FSM to LAUNCH with `valid_count` = the resulting `count`.
    - If a transfer happens in the same cycle, the word is captured first and included in the count.
  - Slots at index ≥ `valid_count` are zeroed on the same edge.
  - `flush` is ignored when the resulting count would be 0.
  - `flush` is ignored in LAUNCH.
  - A flush coinciding with the Nth transfer behaves as a normal full frame.
- Not defined:
  - `flush` is ignored; the port remains for interface stability.
  - `valid_count` is always NUM_OPERANDS at `start`.

## Test plan
- Defaults, `imc_ready`=1, words 0x1111, 0x2222, 0x3333, 0x4444 on consecutive cycles:
  - `start` pulses in the cycle after the 4th capture.
  - `operands` = 0x4444_3333_2222_1111, `valid_count` = 4.
  - `data_accept` is low for exactly one cycle.
- Full frame with `imc_ready`=0 for 5 cycles, `data_valid` held high with 0xAAAA:
  - `busy` = 1 and `data_accept` = 0 for 5 cycles; `operands` stays unchanged.
  - `start` fires when `imc_ready` rises.
  - 0xAAAA is captured into slot 0 afterwards.
- `rst_n` asserted after 2 words (0xBEEF, 0xCAFE):
  - Next cycle: all outputs are 0.
  - The next 4 words form a fresh frame containing no 0xBEEF or 0xCAFE.
- DATA_WIDTH=8, NUM_OPERANDS=6, words 1..6:
  - `operands` = 48'h060504030201, `valid_count` = 6.
- With `IMC_PACKER_FLUSH_EN`, 2 words 0x0A, 0x0B then `flush`:
  - `start` fires with `valid_count` = 2 and `operands` = 0x0000_0000_000B_000A.
  - `flush` with count 0 produces no `start`.
- Without `IMC_PACKER_FLUSH_EN`, the same flush stimulus:
  - No `start` until 2 more words arrive.
  - `valid_count` = 4 at `start`.

Source files
------------

// File: rtl/imc_operand_packer.sv
// imc_operand_packer
//   Collects NUM_OPERANDS words from a valid/accept producer into a flat
//   parallel frame, then hands the frame to the IMC core with a one-cycle
//   start pulse once the core reports imc_ready.
//
// Optional feature macro: IMC_PACKER_FLUSH_EN
//   When defined, a flush request launches a partial frame. Unused slots
//   are zeroed and valid_count reports the partial size. When undefined,
//   the flush port is ignored.
//
// Parameters
//   DATA_WIDTH   : width of one operand word
//   NUM_OPERANDS : words per frame (2..16)
//   CNT_W        : counter width, $clog2(NUM_OPERANDS+1)
//
// Ports
//   clk         : clock, all state changes on the rising edge
//   rst_n       : synchronous reset, ACTIVE HIGH despite the suffix
//   data_in     : operand word from the producer
//   data_valid  : producer offers data_in this cycle
//   data_accept : packer can take a word this cycle
//   imc_ready   : IMC core can take a frame
//   start       : one-cycle frame handoff pulse
//   operands    : packed frame, slot i at [i*DATA_WIDTH +: DATA_WIDTH]
//   valid_count : number of meaningful slots, valid while start is high
//   busy        : a frame is waiting for launch
//   flush       : request launch of a partial frame
module imc_operand_packer #(
   parameter  int DATA_WIDTH   = 16,
   parameter  int NUM_OPERANDS = 4,
   localparam int CNT_W        = $clog2(NUM_OPERANDS + 1)
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic [DATA_WIDTH-1:0]              data_in,
   input  logic                               data_valid,
   output logic                               data_accept,
   input  logic                               imc_ready,
   output logic                               start,
   output logic [NUM_OPERANDS*DATA_WIDTH-1:0] operands,
   output logic [CNT_W-1:0]                   valid_count,
   output logic                               busy,
   input  logic                               flush
);

   typedef enum logic {
      COLLECT = 1'b0,
      LAUNCH  = 1'b1
   } state_t;

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic [CNT_W-1:0]      vcount_q, vcount_d;
   logic [DATA_WIDTH-1:0] slot_q [NUM_OPERANDS];

   logic                  xfer;
   logic [CNT_W-1:0]      new_count;
   logic                  full;
   logic                  flush_go;
   logic [NUM_OPERANDS*DATA_WIDTH-1:0] packed_frame;

   // A transfer only happens while collecting; reset gating of the visible
   // accept does not matter here because reset overrides every register.
   assign xfer      = data_valid && (state_q == COLLECT);
   assign new_count = xfer ? count_q + CNT_W'(1) : count_q;
   assign full      = xfer && (count_q == CNT_W'(NUM_OPERANDS - 1));

`ifdef IMC_PACKER_FLUSH_EN
   // The word arriving with the flush is counted first; an empty frame is
   // never launched.
   assign flush_go = flush && (state_q == COLLECT) && (new_count != '0);
`else
   logic unused_flush;
   assign unused_flush = flush;
   assign flush_go     = 1'b0;
`endif

   // NOTE: every variable gets a default at the top of the block so no
   // path can leave it unassigned and infer a latch.
   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      vcount_d = vcount_q;
      case (state_q)
         COLLECT: begin
            count_d = new_count;
            if (full) begin
               state_d  = LAUNCH;
               vcount_d = CNT_W'(NUM_OPERANDS);
            end else if (flush_go) begin
               state_d  = LAUNCH;
               vcount_d = new_count;
            end
         end
         LAUNCH: begin
            if (imc_ready) begin
               state_d = COLLECT;
               count_d = '0;
            end
         end
         default: begin
            state_d = COLLECT;
            count_d = '0;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         state_q  <= COLLECT;
         count_q  <= '0;
         vcount_q <= '0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         vcount_q <= vcount_d;
      end
   end

   // NOTE: the slot storage is reset explicitly because a discarded frame
   // must never reappear on operands after reset.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         for (int i = 0; i < NUM_OPERANDS; i++) slot_q[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_OPERANDS; i++) begin
            if (xfer && (count_q == CNT_W'(i))) begin
               slot_q[i] <= data_in;
            end else if (flush_go && (CNT_W'(i) >= new_count)) begin
               // Partial frame: clear stale words above the reported size.
               slot_q[i] <= '0;
            end
         end
      end
   end

   always_comb begin
      packed_frame = '0;
      for (int i = 0; i < NUM_OPERANDS; i++) begin
         packed_frame[i*DATA_WIDTH +: DATA_WIDTH] = slot_q[i];
      end
   end

   // All outputs read as zero during the reset cycle itself.
   assign data_accept = !rst_n && (state_q == COLLECT);
   assign busy        = !rst_n && (state_q == LAUNCH);
   assign start       = !rst_n && (state_q == LAUNCH) && imc_ready;
   assign operands    = rst_n ? '0 : packed_frame;
   assign valid_count = rst_n ? '0 : vcount_q;

endmodule

// File: tb/tb_imc_operand_packer.sv
module tb_imc_operand_packer;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   // Default configuration: 4 x 16 bit
   logic        rst_n, data_valid, data_accept, imc_ready, start, busy, flush;
   logic [15:0] data_in;
   logic [63:0] operands;
   logic [2:0]  valid_count;

   imc_operand_packer dut (
      .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_valid(data_valid),
      .data_accept(data_accept), .imc_ready(imc_ready), .start(start),
      .operands(operands), .valid_count(valid_count), .busy(busy), .flush(flush)
   );

   // Alternate configuration: 6 x 8 bit
   logic        rst2, valid2, accept2, ready2, start2, busy2, flush2;
   logic [7:0]  data2;
   logic [47:0] ops2;
   logic [2:0]  vc2;

   imc_operand_packer #(.DATA_WIDTH(8), .NUM_OPERANDS(6)) dut2 (
      .clk(clk), .rst_n(rst2), .data_in(data2), .data_valid(valid2),
      .data_accept(accept2), .imc_ready(ready2), .start(start2),
      .operands(ops2), .valid_count(vc2), .busy(busy2), .flush(flush2)
   );

   typedef struct {
      logic        rst;
      logic [15:0] d;
      logic        v;
      logic        r;
      logic        f;
      logic        acc;
      logic        st;
      logic        bz;
      logic [63:0] ops;
      logic [2:0]  vc;
   } vec_t;

   localparam int NV = 39;
   vec_t tbl [NV];
   int   nfill = 0;
   int   checks = 0;
   int   failures = 0;

   task automatic vec(input logic rst, input logic [15:0] d, input logic v,
                      input logic r, input logic f, input logic acc,
                      input logic st, input logic bz, input logic [63:0] ops,
                      input logic [2:0] vc);
      tbl[nfill] = '{rst, d, v, r, f, acc, st, bz, ops, vc};
      nfill++;
   endtask

   task automatic check(input string name, input logic [63:0] got,
                        input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   initial begin
      bit found;
      // ---------------- vector table ----------------
      //   rst d        v  r  f   acc st bz  operands                  vc
      vec(1, 16'h0000, 0, 0, 0,  0, 0, 0, 64'h0, 0);
      vec(1, 16'h0000, 0, 0, 0,  0, 0, 0, 64'h0, 0);
      // back-to-back full frame with imc_ready high
      vec(0, 16'h1111, 1, 1, 0,  1, 0, 0, 64'h0, 0);
      vec(0, 16'h2222, 1, 1, 0,  1, 0, 0, 64'h1111, 0);
      vec(0, 16'h3333, 1, 1, 0,  1, 0, 0, 64'h2222_1111, 0);
      vec(0, 16'h4444, 1, 1, 0,  1, 0, 0, 64'h3333_2222_1111, 0);
      vec(0, 16'h5555, 1, 1, 0,  0, 1, 1, 64'h4444_3333_2222_1111, 4);
      vec(0, 16'h0000, 0, 1, 0,  1, 0, 0, 64'h4444_3333_2222_1111, 4);
      // full frame, then imc_ready low for 5 cycles with producer stalled
      vec(0, 16'h0001, 1, 0, 0,  1, 0, 0, 64'h4444_3333_2222_1111, 4);
      vec(0, 16'h0002, 1, 0, 0,  1, 0, 0, 64'h4444_3333_2222_0001, 4);
      vec(0, 16'h0003, 1, 0, 0,  1, 0, 0, 64'h4444_3333_0002_0001, 4);
      vec(0, 16'h0004, 1, 0, 0,  1, 0, 0, 64'h4444_0003_0002_0001, 4);
      for (int k = 0; k < 5; k++)
         vec(0, 16'hAAAA, 1, 0, 0,  0, 0, 1, 64'h0004_0003_0002_0001, 4);
      vec(0, 16'hAAAA, 1, 1, 0,  0, 1, 1, 64'h0004_0003_0002_0001, 4);
      vec(0, 16'hAAAA, 1, 1, 0,  1, 0, 0, 64'h0004_0003_0002_0001, 4);
      // 0xAAAA landed in slot 0; partial frame then reset
      vec(0, 16'hBEEF, 1, 1, 0,  1, 0, 0, 64'h0004_0003_0002_AAAA, 4);
      vec(0, 16'hCAFE, 1, 1, 0,  1, 0, 0, 64'h0004_0003_BEEF_AAAA, 4);
      vec(1, 16'h1234, 1, 1, 1,  0, 0, 0, 64'h0, 0);
      vec(0, 16'h0000, 0, 1, 0,  1, 0, 0, 64'h0, 0);
      vec(0, 16'h0101, 1, 1, 0,  1, 0, 0, 64'h0, 0);
      vec(0, 16'h0202, 1, 1, 0,  1, 0, 0, 64'h0101, 0);
      vec(0, 16'h0303, 1, 1, 0,  1, 0, 0, 64'h0202_0101, 0);
      vec(0, 16'h0404, 1, 1, 0,  1, 0, 0, 64'h0303_0202_0101, 0);
      vec(0, 16'h0000, 0, 1, 0,  0, 1, 1, 64'h0404_0303_0202_0101, 4);
      vec(0, 16'h0000, 0, 0, 0,  1, 0, 0, 64'h0404_0303_0202_0101, 4);
      // two words then flush
      vec(0, 16'h000A, 1, 1, 0,  1, 0, 0, 64'h0404_0303_0202_0101, 4);
      vec(0, 16'h000B, 1, 1, 0,  1, 0, 0, 64'h0404_0303_0202_000A, 4);
      vec(0, 16'h0000, 0, 1, 1,  1, 0, 0, 64'h0404_0303_000B_000A, 4);
`ifdef IMC_PACKER_FLUSH_EN
      vec(0, 16'h0000, 0, 1, 0,  0, 1, 1, 64'h0000_0000_000B_000A, 2);
      // flush with count 0 is ignored
      vec(0, 16'h0000, 0, 1, 1,  1, 0, 0, 64'h0000_0000_000B_000A, 2);
      vec(0, 16'h000C, 1, 1, 0,  1, 0, 0, 64'h0000_0000_000B_000A, 2);
      vec(0, 16'h000D, 1, 1, 0,  1, 0, 0, 64'h0000_0000_000B_000C, 2);
      vec(0, 16'h0000, 0, 1, 0,  1, 0, 0, 64'h0000_0000_000D_000C, 2);
      // flush with a same-cycle transfer includes that word
      vec(0, 16'h000E, 1, 1, 1,  1, 0, 0, 64'h0000_0000_000D_000C, 2);
      vec(0, 16'h0000, 0, 1, 0,  0, 1, 1, 64'h0000_000E_000D_000C, 3);
`else
      vec(0, 16'h0000, 0, 1, 0,  1, 0, 0, 64'h0404_0303_000B_000A, 4);
      vec(0, 16'h0000, 0, 1, 1,  1, 0, 0, 64'h0404_0303_000B_000A, 4);
      vec(0, 16'h000C, 1, 1, 0,  1, 0, 0, 64'h0404_0303_000B_000A, 4);
      vec(0, 16'h000D, 1, 1, 0,  1, 0, 0, 64'h0404_000C_000B_000A, 4);
      vec(0, 16'h0000, 0, 1, 0,  0, 1, 1, 64'h000D_000C_000B_000A, 4);
      vec(0, 16'h0000, 0, 1, 1,  1, 0, 0, 64'h000D_000C_000B_000A, 4);
      vec(0, 16'h0000, 0, 1, 0,  1, 0, 0, 64'h000D_000C_000B_000A, 4);
`endif

      // ---------------- initial drive ----------------
      rst_n = 1'b1; data_in = '0; data_valid = 1'b0; imc_ready = 1'b0; flush = 1'b0;
      rst2 = 1'b1;  data2 = '0;   valid2 = 1'b0;     ready2 = 1'b0;    flush2 = 1'b0;

      // ---------------- table-driven run ----------------
      for (int i = 0; i < nfill; i++) begin
         @(negedge clk);
         rst_n      = tbl[i].rst;
         data_in    = tbl[i].d;
         data_valid = tbl[i].v;
         imc_ready  = tbl[i].r;
         flush      = tbl[i].f;
         #1;
         check($sformatf("r%0d_accept", i), 64'(data_accept), 64'(tbl[i].acc));
         check($sformatf("r%0d_start", i),  64'(start),       64'(tbl[i].st));
         check($sformatf("r%0d_busy", i),   64'(busy),        64'(tbl[i].bz));
         check($sformatf("r%0d_operands", i), operands,       tbl[i].ops);
         check($sformatf("r%0d_vcount", i), 64'(valid_count), 64'(tbl[i].vc));
      end

      // ---------------- 6 x 8 configuration, words 1..6 ----------------
      @(negedge clk);
      #1;
      check("w8_reset_ops", 64'(ops2), 64'h0);
      check("w8_reset_accept", 64'(accept2), 64'h0);
      rst2 = 1'b0; ready2 = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         data2  = 8'(k);
         valid2 = 1'b1;
         #1;
         check($sformatf("w8_accept%0d", k), 64'(accept2), 64'h1);
      end
      found = 1'b0;
      for (int c = 0; c < 10 && !found; c++) begin
         @(negedge clk);
         valid2 = 1'b0;
         #1;
         if (start2) found = 1'b1;
      end
      check("w8_start_seen", 64'(found), 64'h1);
      check("w8_operands", 64'(ops2), 64'h0000_0605_0403_0201);
      check("w8_vcount", 64'(vc2), 64'd6);
      @(negedge clk);
      #1;
      check("w8_start_single", 64'(start2), 64'h0);
      check("w8_accept_back", 64'(accept2), 64'h1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
